// File: rtl/wb_chk_pkg.sv
// Shared types for the Wishbone target checker: FSM states,
// violation bit positions and the violation vector width.
package wb_chk_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } chk_state_e;

  localparam int VIO_WIDTH = 8;

  localparam int VIO_RST_BUS    = 0;
  localparam int VIO_STB_NO_CYC = 1;
  localparam int VIO_MULTI_TERM = 2;
  localparam int VIO_SPUR_TERM  = 3;
  localparam int VIO_OVERFLOW   = 4;
  localparam int VIO_TIMEOUT    = 5;
  localparam int VIO_CYC_DROP   = 6;
  localparam int VIO_UNSTABLE   = 7;

endpackage

// File: rtl/wb_chk_sat_cnt.sv
// Saturating up-counter with clear (clear wins over increment).
// Ports: clk_i, async_rst_i, clr_i, inc_i in; cnt_o count, hit_o high when
// this increment lands on MAX.
module wb_chk_sat_cnt #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = inc_i && (cnt_q == MAX - 1'b1);

endmodule

// File: rtl/wb_tgt_chk.sv
// Passive protocol checker for a pipelined Wishbone target port.
// In: clk_i, async_rst_i, sync_rst_i, monitored tgt_* bus, clr_i.
// Out: vio_o sticky flags, irq_o, outstanding_o, req_cnt_o, term_cnt_o.
module wb_tgt_chk
  import wb_chk_pkg::*;
#(
  parameter int ADR_WIDTH       = 16,
  parameter int DAT_WIDTH       = 16,
  parameter int SEL_WIDTH       = 2,
  parameter int TGA_WIDTH       = 1,
  parameter int TGC_WIDTH       = 1,
  parameter int TGWD_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255,
  parameter int CNT_WIDTH       = 16,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  tgt_cyc_o,
  input  logic                  tgt_stb_o,
  input  logic                  tgt_we_o,
  input  logic                  tgt_lock_o,
  input  logic [SEL_WIDTH-1:0]  tgt_sel_o,
  input  logic [ADR_WIDTH-1:0]  tgt_adr_o,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_o,
  input  logic [TGA_WIDTH-1:0]  tgt_tga_o,
  input  logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  input  logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic                  clr_i,
  output logic [VIO_WIDTH-1:0]  vio_o,
  output logic                  irq_o,
  output logic [OUT_W-1:0]      outstanding_o,
  output logic [CNT_WIDTH-1:0]  req_cnt_o,
  output logic [CNT_WIDTH-1:0]  term_cnt_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  chk_state_e state_q, state_d;

  logic [OUT_W-1:0]     out_q, out_d;
  logic [VIO_WIDTH-1:0] vio_q, vio_d;
  logic [VIO_WIDTH-1:0] vio_set;
  logic                 irq_q, irq_d;
  logic                 cyc_q;
  logic                 held_q;

  logic                  we_q;
  logic                  lock_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [ADR_WIDTH-1:0]  adr_q;
  logic [DAT_WIDTH-1:0]  dat_q;
  logic [TGA_WIDTH-1:0]  tga_q;
  logic [TGC_WIDTH-1:0]  tgc_q;
  logic [TGWD_WIDTH-1:0] tgd_q;

  logic cyc_stb;
  logic req;
  logic term;
  logic multi;
  logic ctl_dif;
  logic wd_dif;

  logic             tmo_inc;
  logic             tmo_clr;
  logic             tmo_hit;
  logic [TMO_W-1:0] tmo_unused_cnt;
  logic             req_hit_unused;
  logic             term_hit_unused;

  assign cyc_stb = tgt_cyc_o & tgt_stb_o;
  assign req     = cyc_stb & ~tgt_stall_i;
  assign term    = tgt_ack_i | tgt_err_i | tgt_rty_i;
  assign multi   = (tgt_ack_i & tgt_err_i) |
                   (tgt_ack_i & tgt_rty_i) |
                   (tgt_err_i & tgt_rty_i);

  assign ctl_dif = (tgt_we_o != we_q) |
                   (tgt_lock_o != lock_q) |
                   (tgt_sel_o != sel_q) |
                   (tgt_adr_o != adr_q) |
                   (tgt_tga_o != tga_q) |
                   (tgt_tgc_o != tgc_q);
  assign wd_dif  = (tgt_dat_o != dat_q) |
                   (tgt_tgd_o != tgd_q);

  // Open-request tracking; a dropped cycle aborts everything.
  always_comb begin
    out_d = out_q;
    if ((state_q == ST_RESET) || !tgt_cyc_o) begin
      out_d = '0;
    end else if (req && !term) begin
      if (out_q != MAX_OUT) out_d = out_q + 1'b1;
    end else if (term && !req) begin
      if (out_q != '0) out_d = out_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (req) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if ((out_d == '0) || !tgt_cyc_o) state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Timer runs only while staying busy with no termination.
  assign tmo_inc = (state_q == ST_BUSY) & ~term;
  assign tmo_clr = sync_rst_i | term |
                   (state_q != ST_BUSY) |
                   (state_d != ST_BUSY);

  always_comb begin
    vio_set = '0;
    vio_set[VIO_RST_BUS]    = (state_q == ST_RESET) &
                              (tgt_cyc_o | tgt_stb_o);
    vio_set[VIO_STB_NO_CYC] = tgt_stb_o & ~tgt_cyc_o;
    vio_set[VIO_MULTI_TERM] = multi;
    vio_set[VIO_SPUR_TERM]  = term & tgt_cyc_o & (out_q == '0);
    vio_set[VIO_OVERFLOW]   = req & ~term & (out_q == MAX_OUT);
    vio_set[VIO_TIMEOUT]    = tmo_hit;
    vio_set[VIO_CYC_DROP]   = cyc_q & ~tgt_cyc_o & (out_q != '0);
    vio_set[VIO_UNSTABLE]   = held_q & tgt_stb_o &
                              (ctl_dif | (tgt_we_o & wd_dif));
  end

  always_comb begin
    vio_d = (clr_i ? '0 : vio_q) | vio_set;
    irq_d = |vio_q;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= ST_RESET;
      out_q   <= '0;
      vio_q   <= '0;
      irq_q   <= 1'b0;
      cyc_q   <= 1'b0;
      held_q  <= 1'b0;
    end else if (sync_rst_i) begin
      state_q <= ST_RESET;
      out_q   <= '0;
      vio_q   <= '0;
      irq_q   <= 1'b0;
      cyc_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vio_q   <= vio_d;
      irq_q   <= irq_d;
      cyc_q   <= tgt_cyc_o;
      held_q  <= cyc_stb & tgt_stall_i;
    end
  end

  // Reference copy of the request presented while stalled.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      we_q   <= 1'b0;
      lock_q <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      tga_q  <= '0;
      tgc_q  <= '0;
      tgd_q  <= '0;
    end else if (sync_rst_i) begin
      we_q   <= 1'b0;
      lock_q <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      tga_q  <= '0;
      tgc_q  <= '0;
      tgd_q  <= '0;
    end else if (cyc_stb) begin
      we_q   <= tgt_we_o;
      lock_q <= tgt_lock_o;
      sel_q  <= tgt_sel_o;
      adr_q  <= tgt_adr_o;
      dat_q  <= tgt_dat_o;
      tga_q  <= tgt_tga_o;
      tgc_q  <= tgt_tgc_o;
      tgd_q  <= tgt_tgd_o;
    end
  end

  wb_chk_sat_cnt #(
    .WIDTH (TMO_W),
    .MAX   (TMO_MAX)
  ) u_tmo_cnt (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .clr_i       (tmo_clr),
    .inc_i       (tmo_inc),
    .cnt_o       (tmo_unused_cnt),
    .hit_o       (tmo_hit)
  );

  wb_chk_sat_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_req_cnt (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .clr_i       (sync_rst_i),
    .inc_i       (req),
    .cnt_o       (req_cnt_o),
    .hit_o       (req_hit_unused)
  );

  wb_chk_sat_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_term_cnt (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .clr_i       (sync_rst_i),
    .inc_i       (term),
    .cnt_o       (term_cnt_o),
    .hit_o       (term_hit_unused)
  );

  assign vio_o         = vio_q;
  assign irq_o         = irq_q;
  assign outstanding_o = out_q;

endmodule

// File: tb/tb_wb_tgt_chk.sv
// Randomised and directed bench for wb_tgt_chk against an
// abstract cycle model of the checker rules.
module tb_wb_tgt_chk;

  localparam int MAXO = 4;
  localparam int TMO  = 16;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  localparam int F_VIO = 0;
  localparam int F_IRQ = 1;
  localparam int F_OUT = 2;
  localparam int F_RQ  = 3;
  localparam int F_TM  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        async_rst, sync_rst, clr;
  logic        cyc, stb, we, lock;
  logic [1:0]  sel;
  logic [15:0] adr, dat;
  logic        tga, tgc, tgd;
  logic        ack, err, rty, stall;
  logic [7:0]  vio;
  logic        irq;
  logic [2:0]  outst;
  logic [7:0]  rq_cnt, tm_cnt;

  wb_tgt_chk #(
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT         (TMO),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i         (clk),
    .async_rst_i   (async_rst),
    .sync_rst_i    (sync_rst),
    .tgt_cyc_o     (cyc),
    .tgt_stb_o     (stb),
    .tgt_we_o      (we),
    .tgt_lock_o    (lock),
    .tgt_sel_o     (sel),
    .tgt_adr_o     (adr),
    .tgt_dat_o     (dat),
    .tgt_tga_o     (tga),
    .tgt_tgc_o     (tgc),
    .tgt_tgd_o     (tgd),
    .tgt_ack_i     (ack),
    .tgt_err_i     (err),
    .tgt_rty_i     (rty),
    .tgt_stall_i   (stall),
    .clr_i         (clr),
    .vio_o         (vio),
    .irq_o         (irq),
    .outstanding_o (outst),
    .req_cnt_o     (rq_cnt),
    .term_cnt_o    (tm_cnt)
  );

  // Model state: phase 0 = reset, 1 = idle, 2 = busy.
  int         m_state, m_out, m_tmo, m_rq, m_tm;
  logic [7:0] m_vio;
  bit         m_irq, m_cyc_prev, m_held;
  bit         c_we, c_lock, c_tga, c_tgc, c_tgd;
  logic [1:0]  c_sel;
  logic [15:0] c_adr, c_dat;

  typedef struct {
    int    field;
    int    val;
    string name;
  } lit_t;
  lit_t lits[$];

  bit done = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic m_reset();
    m_state = 0; m_out = 0; m_tmo = 0; m_rq = 0; m_tm = 0;
    m_vio = 8'h00; m_irq = 0; m_cyc_prev = 0; m_held = 0;
    c_we = 0; c_lock = 0; c_tga = 0; c_tgc = 0; c_tgd = 0;
    c_sel = '0; c_adr = '0; c_dat = '0;
  endtask

  task automatic model_tick();
    bit r, t, dif;
    int nt, no, ns;
    logic [7:0] s;
    if (sync_rst) begin
      m_reset();
      return;
    end
    r  = cyc && stb && !stall;
    t  = ack || err || rty;
    nt = int'(ack) + int'(err) + int'(rty);
    s  = 8'h00;
    if (m_state == 0 && (cyc || stb)) s[0] = 1'b1;
    if (stb && !cyc) s[1] = 1'b1;
    if (nt > 1) s[2] = 1'b1;
    if (t && cyc && m_out == 0) s[3] = 1'b1;
    if (r && !t && m_out == MAXO) s[4] = 1'b1;
    if (m_state == 2 && !t && m_tmo == TMO - 1) s[5] = 1'b1;
    if (m_cyc_prev && !cyc && m_out > 0) s[6] = 1'b1;
    dif = (we != c_we) || (lock != c_lock) || (sel != c_sel) ||
          (adr != c_adr) || (tga != c_tga) || (tgc != c_tgc) ||
          (we && (dat != c_dat || tgd != c_tgd));
    if (m_held && stb && dif) s[7] = 1'b1;
    if (m_state == 0 || !cyc) no = 0;
    else begin
      no = m_out + int'(r) - int'(t);
      if (no < 0) no = 0;
      if (no > MAXO) no = MAXO;
    end
    if (m_state == 0) ns = 1;
    else if (m_state == 1) ns = r ? 2 : 1;
    else ns = (no == 0 || !cyc) ? 1 : 2;
    if (m_state == 2 && ns == 2 && !t)
      m_tmo = (m_tmo + 1 > TMO) ? TMO : m_tmo + 1;
    else
      m_tmo = 0;
    m_irq = |m_vio;
    m_vio = (clr ? 8'h00 : m_vio) | s;
    if (r && m_rq < CMAX) m_rq++;
    if (t && m_tm < CMAX) m_tm++;
    m_held = cyc && stb && stall;
    if (cyc && stb) begin
      c_we = we; c_lock = lock; c_sel = sel; c_adr = adr;
      c_dat = dat; c_tga = tga; c_tgc = tgc; c_tgd = tgd;
    end
    m_cyc_prev = cyc;
    m_out = no;
    m_state = ns;
  endtask

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int dut_field(int f);
    case (f)
      F_VIO:   return int'(vio);
      F_IRQ:   return int'(irq);
      F_OUT:   return int'(outst);
      F_RQ:    return int'(rq_cnt);
      default: return int'(tm_cnt);
    endcase
  endfunction

  // Single compare process: model every cycle, then pinned literals.
  int lit_rd = 0;
  always @(negedge clk) begin
    if (!done) begin
      check("vio", int'(vio), int'(m_vio));
      check("irq", int'(irq), int'(m_irq));
      check("outstanding", int'(outst), m_out);
      check("req_cnt", int'(rq_cnt), m_rq);
      check("term_cnt", int'(tm_cnt), m_tm);
    end
    while (lit_rd < lits.size()) begin
      check(lits[lit_rd].name, dut_field(lits[lit_rd].field),
            lits[lit_rd].val);
      lit_rd++;
    end
  end

  task automatic lit(int f, int v, string nm);
    lit_t l;
    l.field = f; l.val = v; l.name = nm;
    lits.push_back(l);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; lock = 0; sel = '0; adr = '0;
    dat = '0; tga = 0; tgc = 0; tgd = 0;
    ack = 0; err = 0; rty = 0; stall = 0; clr = 0;
  endtask

  task automatic sreset();
    bus_idle();
    sync_rst = 1;
    step();
    sync_rst = 0;
    step();
  endtask

  initial begin
    bus_idle();
    sync_rst = 0;
    async_rst = 1;
    m_reset();
    #12;
    async_rst = 0;
    lit(F_VIO, 0, "rst_vio");
    lit(F_OUT, 0, "rst_out");
    step();

    // Reset behaviour
    cyc = 1; stb = 1;
    step();
    step();
    lit(F_OUT, 2, "pre_arst_out");
    @(negedge clk);
    #1;
    async_rst = 1;
    m_reset();
    #1;
    lit(F_OUT, 0, "arst_out");
    lit(F_RQ, 0, "arst_rq");
    @(negedge clk);
    #2;
    async_rst = 0;
    stb = 0;
    step();
    lit(F_VIO, 8'h01, "rst_bus_vio");
    cyc = 0;
    step();
    lit(F_IRQ, 1, "rst_bus_irq");
    sreset();

    // Pipelined burst
    for (int i = 0; i < 3; i++) begin
      cyc = 1; stb = 1;
      step();
      lit(F_OUT, i + 1, "burst_req_out");
    end
    stb = 0; ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit(F_OUT, 2 - i, "burst_ack_out");
    end
    ack = 0; cyc = 0;
    step();
    lit(F_RQ, 3, "burst_rq");
    lit(F_TM, 3, "burst_tm");
    lit(F_VIO, 0, "burst_vio");
    sreset();

    // Overflow
    cyc = 1; stb = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      lit(F_OUT, (i < 4) ? i + 1 : 4, "ovf_out");
    end
    lit(F_VIO, 8'h10, "ovf_vio");
    sreset();
    cyc = 1; stb = 1;
    for (int i = 0; i < 4; i++) step();
    ack = 1;
    step();
    lit(F_OUT, 4, "ovf_net0_out");
    lit(F_VIO, 0, "ovf_net0_vio");
    sreset();

    // Stall stability
    cyc = 1; stb = 1; stall = 1; adr = 16'h1234;
    step();
    adr = 16'h1235;
    step();
    lit(F_VIO, 8'h80, "unstable_vio");
    step();
    lit(F_IRQ, 1, "unstable_irq");
    sreset();
    cyc = 1; stb = 1; stall = 1; we = 0; dat = 16'h1111;
    step();
    dat = 16'h2222;
    step();
    lit(F_VIO, 0, "rd_dat_vio");
    sreset();

    // Timeout then spurious
    cyc = 1; stb = 1;
    step();
    stb = 0;
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i == TMO - 1) lit(F_VIO, 0, "tmo_early_vio");
    end
    lit(F_VIO, 8'h20, "tmo_vio");
    ack = 1;
    step();
    lit(F_OUT, 0, "tmo_ack_out");
    lit(F_VIO, 8'h20, "tmo_ack_vio");
    step();
    lit(F_VIO, 8'h28, "spur_vio");
    sreset();

    // Multi-term and clear
    cyc = 1; stb = 1;
    step();
    stb = 0; ack = 1; err = 1;
    step();
    lit(F_VIO, 8'h04, "multi_vio");
    ack = 0; err = 0; cyc = 0; clr = 1;
    step();
    lit(F_VIO, 0, "clr_vio");
    clr = 0;
    step();
    lit(F_IRQ, 0, "clr_irq");
    clr = 1; stb = 1;
    step();
    lit(F_VIO, 8'h02, "clr_set_vio");
    sreset();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bit quiet;
      quiet = (n % 200) > 150;
      sync_rst = ($urandom_range(0, 599) == 0);
      cyc = ($urandom_range(0, 9) != 0);
      stb = cyc ? ($urandom_range(0, 2) != 0)
                : ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) adr = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) dat = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) we = ~we;
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) tgd = ~tgd;
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      ack = !quiet && ($urandom_range(0, 2) == 0);
      err = !quiet && ($urandom_range(0, 15) == 0);
      rty = !quiet && ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 24) == 0);
      step();
    end
    sync_rst = 0;

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
